// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_MAX_BURST = 4;

    localparam int OWNER_W = 3;   // enough to index up to 8 requesters
    localparam int BEAT_W  = 4;   // enough to count up to 15 beats
    localparam int COUNT_W = 16;  // total accepted beats, wraps

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first requester with req high, searching upward
// from (last_owner + 1) mod nreq with wrap-around. Purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int nreq = DEF_NREQ
) (
    input  logic [nreq-1:0]    req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic               valid,
    output logic [OWNER_W-1:0] index
);

    logic [7:0]         req_pad;
    logic [OWNER_W-1:0] cand [nreq];
    logic [nreq-1:0]    hit;

    // Widen req to 8 bits so any 3-bit candidate index is in range
    always_comb begin
        req_pad            = '0;
        req_pad[nreq-1:0]  = req;
    end

    // Candidate gi is the (gi+1)-th requester after last_owner, wrapped mod nreq
    generate
        for (genvar gi = 0; gi < nreq; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum      = {1'b0, last_owner} + 4'(gi + 1);
            assign cand[gi] = (sum >= 4'(nreq)) ? 3'(sum - 4'(nreq)) : sum[2:0];
            assign hit[gi]  = req_pad[cand[gi]];
        end
    endgenerate

    // Lowest-offset hit wins; scan from the far end so the nearest overrides
    always_comb begin
        valid = |hit;
        index = cand[0];
        for (int k = nreq - 1; k >= 0; k--) begin
            if (hit[k]) begin
                index = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-oriented round-robin arbiter in front of a FIFO write port.
// An owner is picked in IDLE, then streams up to max_burst beats; a dead
// IDLE cycle always separates bursts so arbitration sees fresh requests.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int width     = DEF_WIDTH,
    parameter int nreq      = DEF_NREQ,
    parameter int max_burst = DEF_MAX_BURST
) (
    input  logic                  w_clk,
    input  logic                  rst,
    input  logic [nreq-1:0]       req,
    input  logic [nreq*width-1:0] req_data,
    output logic [nreq-1:0]       gnt,
    input  logic                  full_flag,
    output logic                  w_en,
    output logic [width-1:0]      w_data,
    output logic [OWNER_W-1:0]    owner,
    output logic                  busy,
    output logic [COUNT_W-1:0]    wr_count
);

    state_t             state_q, state_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] last_owner_q, last_owner_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [COUNT_W-1:0] wr_count_q, wr_count_d;

    logic               pick_valid;
    logic [OWNER_W-1:0] pick_index;
    logic [7:0]         req_pad;
    logic [width-1:0]   data_slice [8];
    logic               in_burst;
    logic               owner_req;
    logic [BEAT_W-1:0]  beat_next;

    rr_pick #(
        .nreq (nreq)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    // Widen req so the owner index never selects out of range
    always_comb begin
        req_pad           = '0;
        req_pad[nreq-1:0] = req;
    end

    // Unpack requester data into an 8-entry table; unused entries read zero
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slice
            if (gi < nreq) begin : g_used
                assign data_slice[gi] = req_data[gi*width +: width];
            end else begin : g_unused
                assign data_slice[gi] = '0;
            end
        end
    endgenerate

    // rst is folded in so outputs are quiet the instant reset rises
    assign in_burst  = (state_q == ST_BURST) && !rst;
    assign owner_req = req_pad[owner_q];
    assign w_en      = in_burst && owner_req && !full_flag;
    assign w_data    = in_burst ? data_slice[owner_q] : '0;
    assign busy      = (state_q == ST_BURST);
    assign owner     = owner_q;
    assign wr_count  = wr_count_q;
    assign beat_next = beat_q + 4'd1;

    // Grant mirrors w_en on the owner's lane only
    generate
        for (genvar gi = 0; gi < nreq; gi++) begin : g_gnt
            assign gnt[gi] = w_en && (owner_q == 3'(gi));
        end
    endgenerate

    // Next-state: arbitrate in IDLE, count beats and decide burst end in BURST
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        wr_count_d   = wr_count_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_index;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_en) begin
                    beat_d     = beat_next;
                    wr_count_d = wr_count_q + 16'd1;
                    if (beat_next == 4'(max_burst)) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                    end
                end else if (!owner_req) begin
                    // Owner withdrew; full_flag alone just stalls the burst
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset leaves requester 0 first in line
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= 3'(nreq - 1);
            beat_q       <= '0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
            wr_count_q   <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (width 16, 4 requesters, 4-beat bursts).
module tb_fifo_wr_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           w_clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           full_flag;
    logic           w_en;
    logic [W-1:0]   w_data;
    logic [2:0]     owner;
    logic           busy;
    logic [15:0]    wr_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] exp_data [4];
    logic        exp_b;
    logic        exp_full;

    fifo_wr_arbiter #(
        .width     (W),
        .nreq      (N),
        .max_burst (MB)
    ) dut (
        .w_clk     (w_clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .full_flag (full_flag),
        .w_en      (w_en),
        .w_data    (w_data),
        .owner     (owner),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // A write must never be issued into a full FIFO
    always @(negedge w_clk) begin
        n_assert++;
        assert (!(w_en === 1'b1 && full_flag === 1'b1))
        else begin
            n_fail++;
            $error("FAIL wen_while_full observed w_en=%b full_flag=%b expected w_en=0", w_en, full_flag);
        end
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_data[0] = 16'hA000;
        exp_data[1] = 16'hB001;
        exp_data[2] = 16'hC002;
        exp_data[3] = 16'hD003;
        req_data    = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        rst         = 1'b1;
        req         = '0;
        full_flag   = 1'b0;
        tick();
        tick();

        // Reset state and quiet outputs while rst is held with requests present
        req = 4'b1111;
        settle();
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_gnt",    32'(gnt),      32'd0);
        chk("rst_wen",    32'(w_en),     32'd0);
        chk("rst_wdata",  32'(w_data),   32'd0);
        chk("rst_owner",  32'(owner),    32'd0);
        chk("rst_count",  32'(wr_count), 32'd0);

        // Single requester: 4 beats, one idle cycle, repeated
        req = 4'b0001;
        rst = 1'b0;
        settle();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_gnt",  32'(gnt),  32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            exp_b = ((i % 5) < 4);
            chk($sformatf("t1_busy_%0d", i),  32'(busy),   32'(exp_b));
            chk($sformatf("t1_gnt_%0d", i),   32'(gnt),    exp_b ? 32'd1 : 32'd0);
            chk($sformatf("t1_wdata_%0d", i), 32'(w_data), exp_b ? 32'hA000 : 32'd0);
            tick();
        end
        chk("t1_count8", 32'(wr_count), 32'd8);
        req = 4'b0000;
        settle();
        chk("t1_drop_wen", 32'(w_en), 32'd0);
        tick();
        chk("t1_end_busy",  32'(busy),     32'd0);
        chk("t1_end_count", 32'(wr_count), 32'd8);

        // All requesters from reset: owners 0,1,2,3,0 with their own data
        rst = 1'b1;
        settle();
        rst = 1'b0;
        settle();
        req = 4'b1111;
        settle();
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("t2_gap_%0d", b), 32'(busy), 32'd0);
            tick();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t2_owner_%0d_%0d", b, k), 32'(owner),  32'(b % 4));
                chk($sformatf("t2_gnt_%0d_%0d", b, k),   32'(gnt),    32'(1 << (b % 4)));
                chk($sformatf("t2_wdata_%0d_%0d", b, k), 32'(w_data), 32'(exp_data[b % 4]));
                tick();
            end
        end
        chk("t2_count20", 32'(wr_count), 32'd20);
        req = 4'b0000;
        tick();

        // full_flag on the 2nd and 3rd burst cycles stretches 4 beats over 6 cycles
        req = 4'b0001;
        settle();
        chk("t3_idle_busy", 32'(busy), 32'd0);
        tick();
        for (int c = 1; c <= 6; c++) begin
            exp_full  = (c == 2 || c == 3);
            full_flag = exp_full;
            settle();
            chk($sformatf("t3_wen_c%0d", c),  32'(w_en), exp_full ? 32'd0 : 32'd1);
            chk($sformatf("t3_busy_c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("t3_gnt_c%0d", c),  32'(gnt),  exp_full ? 32'd0 : 32'd1);
            tick();
        end
        full_flag = 1'b0;
        settle();
        chk("t3_after_busy",  32'(busy),     32'd0);
        chk("t3_after_count", 32'(wr_count), 32'd24);
        req = 4'b0000;
        tick();

        // Requester 2 withdraws after 2 beats; requester 3 wins after one idle cycle
        req = 4'b1100;
        settle();
        tick();
        chk("t4_owner2",  32'(owner),  32'd2);
        chk("t4_wen_b1",  32'(w_en),   32'd1);
        chk("t4_wdata2",  32'(w_data), 32'hC002);
        tick();
        chk("t4_wen_b2",  32'(w_en),   32'd1);
        tick();
        req = 4'b1000;
        settle();
        chk("t4_drop_wen",  32'(w_en), 32'd0);
        chk("t4_drop_busy", 32'(busy), 32'd1);
        tick();
        chk("t4_idle_busy", 32'(busy),     32'd0);
        chk("t4_count26",   32'(wr_count), 32'd26);
        tick();
        chk("t4_owner3", 32'(owner),  32'd3);
        chk("t4_gnt3",   32'(gnt),    32'b1000);
        chk("t4_wdata3", 32'(w_data), 32'hD003);
        tick();
        chk("t5_pre_wen", 32'(w_en), 32'd1);

        // Asynchronous reset at beat 2 kills the burst at once
        rst = 1'b1;
        settle();
        chk("t5_rst_wen",   32'(w_en),     32'd0);
        chk("t5_rst_gnt",   32'(gnt),      32'd0);
        chk("t5_rst_busy",  32'(busy),     32'd0);
        chk("t5_rst_wdata", 32'(w_data),   32'd0);
        chk("t5_rst_count", 32'(wr_count), 32'd0);
        req = 4'b1010;
        tick();
        chk("t5_hold_gnt", 32'(gnt),  32'd0);
        chk("t5_hold_wen", 32'(w_en), 32'd0);
        rst = 1'b0;
        settle();
        chk("t5_rel_busy", 32'(busy), 32'd0);
        tick();
        chk("t5_owner1", 32'(owner),  32'd1);
        chk("t5_gnt1",   32'(gnt),    32'b0010);
        chk("t5_wdata1", 32'(w_data), 32'hB001);
        req = 4'b0000;
        tick();
        chk("t6_idle_busy", 32'(busy),     32'd0);
        chk("t6_count0",    32'(wr_count), 32'd0);

        // Counter wrap: preload near the top so the rollover is reached quickly
        force dut.wr_count_q = 16'hFFFD;
        settle();
        release dut.wr_count_q;
        settle();
        chk("t6_preload", 32'(wr_count), 32'hFFFD);
        req = 4'b0001;
        settle();
        tick();
        chk("t6_owner0", 32'(owner), 32'd0);
        tick();
        tick();
        chk("t6_count_ffff", 32'(wr_count), 32'hFFFF);
        tick();
        chk("t6_wrap0",    32'(wr_count), 32'd0);
        chk("t6_wrap_wen", 32'(w_en),     32'd1);
        req = 4'b0000;
        tick();
        chk("t6_end_busy", 32'(busy), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
